traffic_light_sequencer: RTL and testbench
==========================================

TRAFFIC_LIGHT_SEQUENCER -- requirements
Module: traffic_light_sequencer

Interface
REQ-001 Parameter GREEN_TICKS, default 8, sets green phase length in cycles (legal range 1..2^TW).
REQ-002 Parameter YELLOW_TICKS, default 3, sets yellow phase length in cycles.
REQ-003 Parameter ALLRED_TICKS, default 2, sets all-red clearance length in cycles.
REQ-004 Parameter WALK_TICKS, default 6, sets pedestrian walk length in cycles.
REQ-005 Parameter FLASH_TICKS, default 4, sets night flash half-period in cycles.
REQ-006 Parameter TW, default 4, sets phase timer width; every *_TICKS value SHALL be at most 2^TW.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 Port mode, input, 2 bits: traffic mode from the upstream mode register: 00 day, 01 night, 10 pedestrian, 11 emergency.
REQ-010 Port nsLight, output, 3 bits: north-south lamps {red, yellow, green}, one-hot or 000.
REQ-011 Port ewLight, output, 3 bits: east-west lamps {red, yellow, green}, one-hot or 000.
REQ-012 Port walk, output, 1 bit: pedestrian walk lamp.
REQ-013 Port pedAck, output, 1 bit: single-cycle pulse acknowledging a served pedestrian request.

Function
REQ-014 The FSM SHALL have states NS_G, NS_Y, AR1, EW_G, EW_Y, AR2, WALK, FLASH, and EMG; outputs are Moore-decoded from the state register (plus the flash phase).
REQ-015 On entry to any timed state, the timer SHALL load TICKS-1 and decrement each cycle; the state exits on the cycle the timer reads 0, so each timed state lasts exactly TICKS cycles.
REQ-016 Lamp decode: NS_G = ns 001 / ew 100; NS_Y = 010/100; EW_G = 100/001; EW_Y = 100/010; AR1, AR2, WALK, and EMG = 100/100; walk is 1 only in WALK.
REQ-017 Day sequence: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G, giving a 26-cycle period at default parameters.
REQ-018 pedPending SHALL set on any cycle with mode==10 and clear on the cycle WALK is entered; pedAck SHALL pulse high on that same entry cycle.
REQ-019 AR1/AR2 exit priority: mode==11 -> EMG; pedPending -> WALK; mode==01 -> FLASH; otherwise AR1 -> EW_G and AR2 -> NS_G.
REQ-020 WALK SHALL last WALK_TICKS cycles and then go to AR2; a pedestrian request arriving during WALK sets pedPending again.
REQ-021 Green preemption: in NS_G or EW_G with mode==11, 01, or pedPending, the FSM SHALL go next cycle to the matching yellow; yellow always runs its full length.
REQ-022 EMG SHALL hold both roads red with no timer while mode==11; when mode!=11 it goes to AR2 with ALLRED_TICKS loaded.
REQ-023 FLASH: the flash phase starts at 1 on entry and toggles every FLASH_TICKS cycles.
REQ-024 FLASH lamps: phase 1 gives ns 010 / ew 100; phase 0 gives ns 000 / ew 000.
REQ-025 FLASH exit: mode==11 -> EMG directly; any other mode!=01 -> AR2.
REQ-026 No state SHALL ever be reached that drives green on both roads, or green on one road while walk=1.
REQ-027 When emergency and a pending pedestrian request coincide, the emergency SHALL win and pedPending SHALL be retained through EMG.

Reset
REQ-028 While rst=1 at a clock edge, the FSM SHALL enter AR2 with timer ALLRED_TICKS-1, pedPending=0, flash phase=1.
REQ-029 The reset outputs SHALL be nsLight=100, ewLight=100, walk=0, pedAck=0.
REQ-030 Reset asserted mid-phase (including during WALK or EMG) SHALL abandon that phase with no pedAck pulse.
REQ-031 rst SHALL take priority over all other inputs.

Verification
REQ-032 Reset, then mode=00 held -> 2 cycles of red/red, 8 cycles NS green, 3 NS yellow, 2 all-red, 8 EW green; repeats with a 26-cycle period.
REQ-033 Pulse mode=10 for 1 cycle during NS_G cycle 2 -> next cycle NS_Y (3 cycles), then AR1 (2 cycles), then WALK with pedAck=1 on entry, walk=1 for 6 cycles, then AR2 -> NS_G.
REQ-034 mode=11 during EW_G -> EW_Y 3 cycles, then AR1 2 cycles, then EMG red/red held 20 cycles; mode=00 -> AR2 2 cycles, then NS_G.
REQ-035 mode=01 from reset -> after AR2, FLASH with ns 010 / ew 100 for 4 cycles, then 000/000 for 4 cycles, repeating; mode=11 -> EMG next cycle.
REQ-036 mode=10 then mode=11 before the next all-red -> EMG is served first and pedAck=0; after mode=00, AR2 then WALK with a pedAck pulse.
REQ-037 rst asserted during WALK cycle 3 -> next cycle shows red/red, walk=0, pedAck=0, and NS_G follows 2 cycles after rst is released.

Source files
------------

// File: rtl/traffic_light_sequencer.sv
// Four-way traffic light controller: day cycle, pedestrian walk, night flash and emergency hold.
// Lamps and walk are Moore-decoded from the state register; pedAck is a registered entry pulse.
module traffic_light_sequencer #(
   parameter int GREEN_TICKS  = 8,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 6,
   parameter int FLASH_TICKS  = 4,
   parameter int TW           = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   output logic [2:0] nsLight,
   output logic [2:0] ewLight,
   output logic       walk,
   output logic       pedAck,
   output logic [3:0] dbgState
);

   typedef enum logic [3:0] {
      S_NS_G  = 4'd0,
      S_NS_Y  = 4'd1,
      S_AR1   = 4'd2,
      S_EW_G  = 4'd3,
      S_EW_Y  = 4'd4,
      S_AR2   = 4'd5,
      S_WALK  = 4'd6,
      S_FLASH = 4'd7,
      S_EMG   = 4'd8
   } state_t;

   localparam logic [TW-1:0] L_GREEN  = TW'(GREEN_TICKS - 1);
   localparam logic [TW-1:0] L_YELLOW = TW'(YELLOW_TICKS - 1);
   localparam logic [TW-1:0] L_ALLRED = TW'(ALLRED_TICKS - 1);
   localparam logic [TW-1:0] L_WALK   = TW'(WALK_TICKS - 1);
   localparam logic [TW-1:0] L_FLASH  = TW'(FLASH_TICKS - 1);

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;
   localparam logic [2:0] LAMP_O = 3'b000;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_ped_pending;
   logic          r_flash_phase;
   logic          r_ped_ack;

   state_t        w_state_nxt;
   logic [TW-1:0] w_timer_nxt;
   logic          w_phase_nxt;
   logic          w_ped_nxt;
   logic          w_ack_nxt;
   logic          w_tdone;
   logic          w_emg;
   logic          w_night;
   logic          w_ped;
   logic          w_enter;

   function automatic logic [TW-1:0] f_load(input state_t s);
      case (s)
         S_NS_G, S_EW_G: f_load = L_GREEN;
         S_NS_Y, S_EW_Y: f_load = L_YELLOW;
         S_AR1, S_AR2:   f_load = L_ALLRED;
         S_WALK:         f_load = L_WALK;
         S_FLASH:        f_load = L_FLASH;
         default:        f_load = '0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_AR2;
         r_timer       <= L_ALLRED;
         r_ped_pending <= 1'b0;
         r_flash_phase <= 1'b1;
         r_ped_ack     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_timer       <= w_timer_nxt;
         r_ped_pending <= w_ped_nxt;
         r_flash_phase <= w_phase_nxt;
         r_ped_ack     <= w_ack_nxt;
      end
   end

   always_comb begin
      w_tdone     = (r_timer == '0);
      w_emg       = (mode == 2'b11);
      w_night     = (mode == 2'b01);
      // A request in the current cycle counts as pending so greens react immediately.
      w_ped       = r_ped_pending | (mode == 2'b10);
      w_state_nxt = r_state;
      w_timer_nxt = r_timer - 1'b1;
      w_phase_nxt = r_flash_phase;
      case (r_state)
         S_NS_G:  if (w_emg || w_night || w_ped || w_tdone) w_state_nxt = S_NS_Y;
         S_NS_Y:  if (w_tdone) w_state_nxt = S_AR1;
         S_EW_G:  if (w_emg || w_night || w_ped || w_tdone) w_state_nxt = S_EW_Y;
         S_EW_Y:  if (w_tdone) w_state_nxt = S_AR2;
         S_WALK:  if (w_tdone) w_state_nxt = S_AR2;
         S_AR1, S_AR2: begin
            if (w_tdone) begin
               if (w_emg)               w_state_nxt = S_EMG;
               else if (w_ped)          w_state_nxt = S_WALK;
               else if (w_night)        w_state_nxt = S_FLASH;
               else if (r_state == S_AR1) w_state_nxt = S_EW_G;
               else                     w_state_nxt = S_NS_G;
            end
         end
         S_FLASH: begin
            if (w_emg)             w_state_nxt = S_EMG;
            else if (!w_night)     w_state_nxt = S_AR2;
            else if (w_tdone) begin
               w_phase_nxt = ~r_flash_phase;
               w_timer_nxt = L_FLASH;
            end
         end
         S_EMG: begin
            w_timer_nxt = r_timer;
            if (!w_emg) w_state_nxt = S_AR2;
         end
         default: w_state_nxt = S_AR2;
      endcase

      w_enter = (w_state_nxt != r_state);
      if (w_enter) begin
         w_timer_nxt = f_load(w_state_nxt);
         if (w_state_nxt == S_FLASH) w_phase_nxt = 1'b1;
      end

      w_ack_nxt = w_enter && (w_state_nxt == S_WALK);
      if (w_ack_nxt)            w_ped_nxt = 1'b0;
      else if (mode == 2'b10)   w_ped_nxt = 1'b1;
      else                      w_ped_nxt = r_ped_pending;
   end

   always_comb begin
      nsLight = LAMP_R;
      ewLight = LAMP_R;
      walk    = 1'b0;
      case (r_state)
         S_NS_G:  nsLight = LAMP_G;
         S_NS_Y:  nsLight = LAMP_Y;
         S_EW_G:  ewLight = LAMP_G;
         S_EW_Y:  ewLight = LAMP_Y;
         S_WALK:  walk    = 1'b1;
         S_FLASH: begin
            nsLight = r_flash_phase ? LAMP_Y : LAMP_O;
            ewLight = r_flash_phase ? LAMP_R : LAMP_O;
         end
         default: ;
      endcase
   end

   assign pedAck   = r_ped_ack;
   assign dbgState = r_state;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench: driver pushes the expected lamp vector per cycle; a monitor pops and compares.
module tb_traffic_light_sequencer;

   localparam logic [2:0] LR = 3'b100;
   localparam logic [2:0] LY = 3'b010;
   localparam logic [2:0] LG = 3'b001;
   localparam logic [2:0] LO = 3'b000;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [1:0] mode = 2'b00;
   logic [2:0] nsLight;
   logic [2:0] ewLight;
   logic       walk;
   logic       pedAck;
   logic [3:0] dbgState;

   logic [7:0] exp_q[$];
   logic [7:0] m_exp;
   logic [7:0] m_act;
   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;

   always #5 clk = ~clk;

   traffic_light_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .nsLight  (nsLight),
      .ewLight  (ewLight),
      .walk     (walk),
      .pedAck   (pedAck),
      .dbgState (dbgState)
   );

   // Each pushed entry is the output expected right after the following rising edge.
   task automatic seg(input logic [1:0] m, input logic r, input int n,
                      input logic [2:0] ns, input logic [2:0] ew,
                      input logic w, input logic ack);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mode = m;
         rst  = r;
         exp_q.push_back({ns, ew, w, (i == 0) ? ack : 1'b0});
      end
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         m_exp = exp_q.pop_front();
         m_act = {nsLight, ewLight, walk, pedAck};
         checks++;
         if (m_act !== m_exp) begin
            errors++;
            $display("FAIL lamps cyc %0d: got ns=%b ew=%b walk=%b ack=%b, want ns=%b ew=%b walk=%b ack=%b",
                     cyc, m_act[7:5], m_act[4:2], m_act[1], m_act[0],
                     m_exp[7:5], m_exp[4:2], m_exp[1], m_exp[0]);
         end
         checks++;
         if ((nsLight[0] && ewLight[0]) || (walk && (nsLight[0] || ewLight[0]))) begin
            errors++;
            $display("FAIL safety cyc %0d: got ns=%b ew=%b walk=%b, want no conflicting greens",
                     cyc, nsLight, ewLight, walk);
         end
      end
   end

   initial begin
      // Day cycle from reset, one full 26-cycle period plus the next green.
      seg(2'b00, 1'b1, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 8, LG, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 3, LY, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 8, LR, LG, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 3, LR, LY, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LG, LR, 1'b0, 1'b0);

      // Pedestrian pulse during NS green cycle 2.
      seg(2'b00, 1'b1, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LG, LR, 1'b0, 1'b0);
      seg(2'b10, 1'b0, 1, LY, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LY, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b1, 1'b1);
      seg(2'b00, 1'b0, 5, LR, LR, 1'b1, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LG, LR, 1'b0, 1'b0);

      // Emergency raised during EW green, held 20 cycles in EMG.
      seg(2'b00, 1'b1, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 8, LG, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 3, LY, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LG, 1'b0, 1'b0);
      seg(2'b11, 1'b0, 3, LR, LY, 1'b0, 1'b0);
      seg(2'b11, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b11, 1'b0, 20, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LG, LR, 1'b0, 1'b0);

      // Night flash from reset, then emergency.
      seg(2'b01, 1'b1, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b01, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b01, 1'b0, 4, LY, LR, 1'b0, 1'b0);
      seg(2'b01, 1'b0, 4, LO, LO, 1'b0, 1'b0);
      seg(2'b01, 1'b0, 4, LY, LR, 1'b0, 1'b0);
      seg(2'b01, 1'b0, 2, LO, LO, 1'b0, 1'b0);
      seg(2'b11, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LG, LR, 1'b0, 1'b0);

      // Pedestrian request overtaken by emergency; walk served afterwards.
      seg(2'b00, 1'b1, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LG, LR, 1'b0, 1'b0);
      seg(2'b10, 1'b0, 1, LY, LR, 1'b0, 1'b0);
      seg(2'b11, 1'b0, 2, LY, LR, 1'b0, 1'b0);
      seg(2'b11, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b11, 1'b0, 3, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b1, 1'b1);
      seg(2'b00, 1'b0, 5, LR, LR, 1'b1, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LG, LR, 1'b0, 1'b0);

      // Reset during WALK cycle 3, with a fresh request that reset must discard.
      seg(2'b00, 1'b1, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LG, LR, 1'b0, 1'b0);
      seg(2'b10, 1'b0, 1, LY, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LY, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 2, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b1, 1'b1);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b1, 1'b0);
      seg(2'b10, 1'b0, 1, LR, LR, 1'b1, 1'b0);
      seg(2'b00, 1'b1, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LR, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 8, LG, LR, 1'b0, 1'b0);
      seg(2'b00, 1'b0, 1, LY, LR, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL timeout: got no end of stimulus, want finish before 100000");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
